fp32_normalize_round: RTL and testbench
=======================================

FP32_NORMALIZE_ROUND -- requirements
Module: fp32_normalize_round

Interface
REQ-001 Parameters: none; the only build option is the macro in Configuration.
REQ-002 Ports, in order:
- clk input 1: single clock; all state changes on the rising edge.
- rst_n input 1: reset, synchronous, active-low.
- in_valid input 1: the input beat is valid.
- in_ready output 1: the block accepts a beat this cycle.
- sign_in input 1: result sign (XOR of operand signs).
- exp_in input 10: signed two's-complement biased exponent, already bias-corrected upstream (ea + eb − 127).
- prod_in input 48: unsigned 24x24 mantissa product with hidden bits, binary point between bits 46 and 45.
- out_valid output 1: result valid.
- out_ready input 1: downstream accepts the result.
- result output 32: packed IEEE-754 single-precision result.
- ovf output 1: the result overflowed to infinity.
- unf output 1: the result underflowed and was flushed to zero.

Function
REQ-003 Two-stage pipeline, S1 (normalize) and S2 (round/pack); each stage has its own valid bit.
REQ-004 Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-005 in_ready = !s1_valid || s1_advances; s1_advances = !s2_valid || out_ready. The block is fully combinational-ready with no bubble.
REQ-006 Latency: 2 cycles from input transfer to out_valid when out_ready is held high; throughput 1 beat/cycle.
REQ-007 S1 normalize, case prod_in[47]=1: mantissa = prod_in[47:24], guard = prod_in[23], sticky = |prod_in[22:0], exponent = exp_in+1.
REQ-008 S1 normalize, case prod_in[47]=0: mantissa = prod_in[46:23], guard = prod_in[22], sticky = |prod_in[21:0], exponent = exp_in.
REQ-009 S1 zero: prod_in==0 marks the beat zero; S2 emits {sign,31'b0} with ovf=unf=0.
REQ-010 S2 rounding (Configuration applies); if the rounded mantissa carries out to 25 bits, mantissa = 1.0 and exponent +1.
REQ-011 S2 overflow: final exponent >= 255 gives result = {sign,8'hFF,23'b0} and ovf=1.
REQ-012 S2 underflow: final exponent <= 0 gives result = {sign,31'b0} and unf=1; no subnormals are produced.
REQ-013 Otherwise result = {sign, exponent[7:0], mantissa[22:0]}, ovf=unf=0.
REQ-014 Exponent arithmetic is 11-bit signed internally; no wrap-around is permitted.
REQ-015 Stall: while out_valid && !out_ready, result/ovf/unf/out_valid hold stable and S1 holds if S2 cannot drain.
REQ-016 Simultaneous S2 drain and S1 advance in the same cycle: S2 loads S1's beat, and no beat is lost or duplicated.
REQ-017 Output flags are registered together with result, never combinationally from inputs.

Reset
REQ-018 While rst_n=0 at a clock edge: s1_valid=s2_valid=0, out_valid=0, result=0, ovf=0, unf=0.
REQ-019 in_ready=1 on the first cycle after reset release.
REQ-020 Reset mid-operation discards all in-flight beats; no stale result appears after release.

Configuration
REQ-021 Macro FPMUL_ROUND_RNE_EN.
- Defined: round-to-nearest-even; increment when guard && (sticky || mantissa[0]).
- Undefined: round-toward-zero (truncate); guard and sticky are ignored, and the S2 rounding incrementer is absent.

Verification
REQ-022 prod_in=48'h400000000000, exp_in=127, sign=0 -> result=32'h3F800000, ovf=unf=0, out_valid 2 cycles after input.
REQ-023 prod_in=48'h900000000000, exp_in=127, sign=1 -> result=32'hC0100000.
REQ-024 prod_in=48'h7FFFFFC00000, exp_in=127 -> with FPMUL_ROUND_RNE_EN: 32'h40000000; without it: 32'h3FFFFFFF.
REQ-025 Boundary cases:
- prod_in=48'h800000000000, exp_in=254 -> result=32'h7F800000, ovf=1.
- prod_in=48'h400000000000, exp_in=0 -> result=32'h00000000, unf=1.
REQ-026 Three back-to-back beats with out_ready=0 for 4 cycles -> in_ready drops after the 2nd beat, result holds, and all 3 beats emerge in order once out_ready=1.
REQ-027 Assert rst_n=0 with two beats in flight -> out_valid=0 the next cycle, and no old result appears after release.

Source files
------------

// File: rtl/fp32_normalize_round.sv
`default_nettype none
// ============================================================================
// Module   : fp32_normalize_round
// Purpose  : Two-stage FP32 multiplier back end: normalize a 48-bit mantissa
//            product, then round and pack into IEEE-754 single precision.
// Build    : FPMUL_ROUND_RNE_EN selects round-to-nearest-even (default: truncate)
// Revision : 1.0 - initial release
// ============================================================================
module fp32_normalize_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [9:0]  exp_in,
    input  logic [47:0] prod_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf
);

    localparam logic signed [10:0] c_exp_max = 11'sd255;
    localparam logic signed [10:0] c_exp_min = 11'sd0;

    logic                w_s1_adv;
    logic                r_s1_valid;
    logic                r_s1_sign;
    logic                r_s1_zero;
    logic [23:0]         r_s1_mant;
    logic signed [10:0]  r_s1_exp;

    logic [23:0]         w_n_mant;
    logic signed [10:0]  w_n_exp;

    logic [22:0]         w_r_frac;
    logic signed [10:0]  w_r_exp;

    logic [31:0]         w_res;
    logic                w_ovf;
    logic                w_unf;

    logic                r_s2_valid;
    logic [31:0]         r_result;
    logic                r_ovf;
    logic                r_unf;

    assign w_s1_adv = !r_s2_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s1_adv;

    // A set top bit means the product is in [2,4): take one extra shift.
    assign w_n_mant = prod_in[47] ? prod_in[47:24] : prod_in[46:23];
    assign w_n_exp  = $signed({exp_in[9], exp_in}) + (prod_in[47] ? 11'sd1 : 11'sd0);

`ifdef FPMUL_ROUND_RNE_EN
    logic        r_s1_guard;
    logic        r_s1_sticky;
    logic        w_n_guard;
    logic        w_n_sticky;
    logic        w_inc;
    logic [24:0] w_sum;

    assign w_n_guard  = prod_in[47] ? prod_in[23] : prod_in[22];
    assign w_n_sticky = prod_in[47] ? (|prod_in[22:0]) : (|prod_in[21:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_guard  <= 1'b0;
            r_s1_sticky <= 1'b0;
        end else if (in_valid && in_ready) begin
            r_s1_guard  <= w_n_guard;
            r_s1_sticky <= w_n_sticky;
        end
    end

    assign w_inc    = r_s1_guard && (r_s1_sticky || r_s1_mant[0]);
    assign w_sum    = {1'b0, r_s1_mant} + {24'd0, w_inc};
    // Carry out of 1.111..1 wraps to 1.0 with the exponent bumped.
    assign w_r_frac = w_sum[24] ? 23'd0 : w_sum[22:0];
    assign w_r_exp  = w_sum[24] ? (r_s1_exp + 11'sd1) : r_s1_exp;
`else
    logic w_unused_rnd;

    assign w_unused_rnd = ^{r_s1_mant[23], prod_in[22:0]};
    assign w_r_frac     = r_s1_mant[22:0];
    assign w_r_exp      = r_s1_exp;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_mant  <= 24'd0;
            r_s1_exp   <= 11'sd0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= sign_in;
                r_s1_zero <= (prod_in == 48'd0);
                r_s1_mant <= w_n_mant;
                r_s1_exp  <= w_n_exp;
            end
        end
    end

    always_comb begin
        w_res = {r_s1_sign, 31'd0};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (r_s1_zero) begin
            w_res = {r_s1_sign, 31'd0};
        end else if (w_r_exp >= c_exp_max) begin
            w_res = {r_s1_sign, 8'hFF, 23'd0};
            w_ovf = 1'b1;
        end else if (w_r_exp <= c_exp_min) begin
            w_res = {r_s1_sign, 31'd0};
            w_unf = 1'b1;
        end else begin
            w_res = {r_s1_sign, w_r_exp[7:0], w_r_frac};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= 32'd0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
                r_ovf    <= w_ovf;
                r_unf    <= w_unf;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fp32_normalize_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_normalize_round
// Purpose  : Scoreboard bench for fp32_normalize_round (directed + random beats)
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_normalize_round;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [9:0]  exp_in;
    logic [47:0] prod_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;
    logic        unf;

    int total = 0;
    int bad   = 0;
    bit rand_ready = 0;
    logic [33:0] sb[$];

    fp32_normalize_round dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .prod_in   (prod_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {result, ovf, unf}
    function automatic logic [33:0] model(input logic s, input int e, input logic [47:0] p);
        int          ex;
        logic [47:0] q;
        logic [24:0] m;
        logic        g;
        logic        st;
        if (p == 48'd0) return {s, 31'd0, 2'b00};
        q  = p[47] ? p : (p << 1);
        ex = e + (p[47] ? 1 : 0);
        m  = {1'b0, q[47:24]};
        g  = q[23];
        st = |q[22:0];
`ifdef FPMUL_ROUND_RNE_EN
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = 25'h0800000;
            ex++;
        end
`else
        if (g && st) m = m;
`endif
        if (ex >= 255) return {s, 8'hFF, 23'd0, 2'b10};
        if (ex <= 0)   return {s, 31'd0, 2'b01};
        return {s, ex[7:0], m[22:0], 2'b00};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {32'd0, result}, 64'hDEAD);
            end else begin
                logic [33:0] e;
                e = sb.pop_front();
                check("result", {32'd0, result}, {32'd0, e[33:2]});
                check("ovf", {63'd0, ovf}, {63'd0, e[1]});
                check("unf", {63'd0, unf}, {63'd0, e[0]});
            end
        end
    end

    task automatic send(input logic s, input int e, input logic [47:0] p, input logic [33:0] expv);
        int n;
        n = 0;
        sign_in  = s;
        exp_in   = e[9:0];
        prod_in  = p;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(expv);
                break;
            end
            n++;
            if (n > 60) begin
                check("accept_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rv;
        logic [47:0] p;
        int          e;
        logic        s;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sign_in = 1'b0; exp_in = 10'd0; prod_in = 48'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        check("rst_unf", {63'd0, unf}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

        // One beat: latency and basic value
        send(1'b0, 127, 48'h400000000000, {32'h3F800000, 2'b00});
        check("lat_not_yet", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        check("lat_valid", {63'd0, out_valid}, 64'd1);
        check("lat_result", {32'd0, result}, {32'd0, 32'h3F800000});
        drain();

        send(1'b1, 127, 48'h900000000000, {32'hC0100000, 2'b00});
`ifdef FPMUL_ROUND_RNE_EN
        send(1'b0, 127, 48'h7FFFFFC00000, {32'h40000000, 2'b00});
`else
        send(1'b0, 127, 48'h7FFFFFC00000, {32'h3FFFFFFF, 2'b00});
`endif
        send(1'b0, 254, 48'h800000000000, {32'h7F800000, 2'b10});
        send(1'b0, 0,   48'h400000000000, {32'h00000000, 2'b01});
        send(1'b1, 50,  48'h000000000000, {32'h80000000, 2'b00});
        send(1'b1, -5,  48'h400000000000, {32'h80000000, 2'b01});
        send(1'b0, 1,   48'h400000000000, {32'h00800000, 2'b00});
        drain();

        // Backpressure: three beats into a blocked output
        out_ready = 1'b0;
        send(1'b0, 127, 48'h400000000000, {32'h3F800000, 2'b00});
        send(1'b1, 127, 48'h900000000000, {32'hC0100000, 2'b00});
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        sign_in = 1'b0; exp_in = 10'd128; prod_in = 48'h400000000000; in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("stall_hold_ready", {63'd0, in_ready}, 64'd0);
            check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
            check("stall_hold_result", {32'd0, result}, {32'd0, 32'h3F800000});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(1'b0, 128, 48'h400000000000, {32'h40000000, 2'b00});
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(1'b0, 127, 48'h400000000000, {32'h3F800000, 2'b00});
        send(1'b1, 127, 48'h900000000000, {32'hC0100000, 2'b00});
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (5) begin
            @(negedge clk);
            check("midrst_no_stale", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk); #1;

        // Random beats with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rv = {$urandom, $urandom};
            p  = rv[47:0];
            if ($urandom_range(0, 1) == 1) begin
                p[47] = 1'b1;
            end else begin
                p[47] = 1'b0;
                p[46] = 1'b1;
            end
            if (i % 8 == 3) p[22:0] = 23'h400000;
            e = int'($urandom_range(0, 300)) - 20;
            s = 1'($urandom_range(0, 1));
            send(s, e, p, model(s, e, p));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
